uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
UART transmit framer: the transmit-side counterpart of the receiver's start/parity/stop checking.
- Accepts a parallel byte with a one-cycle valid strobe.
- Serializes it as a start bit, DATA_WIDTH data bits (LSB first), an optional parity bit and one stop bit.
- Sends one bit per clk_txf cycle; clk_txf is the TX baud clock.
- Sits between the host-side data source and the serial TX pin.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
clk_txf  input  1  TX baud clock; all logic is rising-edge.
rst_txf  input  1  asynchronous, active-low reset.
p_data_txf  input  DATA_WIDTH  parallel data to transmit.
data_valid_txf  input  1  single-cycle strobe; p_data_txf is valid.
par_en_txf  input  1  1 = parity bit is inserted.
par_typ_txf  input  1  0 = even parity, 1 = odd parity.
tx_out_txf  output  1  serial line; idles high.
busy_txf  output  1  high while a frame is on the line.

Behaviour:
- Reset is asynchronous and active-low.
  - When rst_txf is low: state=IDLE, tx_out_txf=1, busy_txf=0, and the data/parity latches and bit counter clear to 0.
  - Reset asserted mid-frame aborts the frame immediately; the line returns high with no clock needed.
- Both outputs are registered and change only on a clk_txf rising edge, apart from reset.
- States:
  - IDLE: tx_out=1, busy=0.
    - If data_valid_txf=1 at an edge, latch p_data_txf, par_en_txf and par_typ_txf, then go to START.
    - Otherwise stay in IDLE.
  - START: tx_out=0, busy=1, for 1 cycle, then go to DATA.
  - DATA: tx_out = latched_data[bit_cnt], busy=1.
    - bit_cnt runs 0..DATA_WIDTH-1, giving LSB first.
    - After bit DATA_WIDTH-1, go to PARITY if the latched par_en=1, else go to STOP.
  - PARITY: tx_out = XOR-reduction of latched_data XOR latched par_typ, busy=1, for 1 cycle, then go to STOP.
    - Even parity: total count of ones (data plus parity bit) is even.
  - STOP: tx_out=1, busy=1, for 1 cycle, then go to IDLE.
- Latency: if data_valid_txf is sampled high at edge N, tx_out_txf shows the start bit from edge N to edge N+1.
- Frame length with busy high: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity (10 or 11 for the default).
- After STOP, the block spends at least one cycle in IDLE (tx=1, busy=0) before the next start bit.
- data_valid_txf while busy_txf=1, including during the STOP cycle, is ignored.
  - The frame in flight is not corrupted; the dropped byte is never sent.
- p_data_txf, par_en_txf and par_typ_txf changing mid-frame have no effect; only the latched values are used.
- bit_cnt is wide enough to hold DATA_WIDTH-1. It is reset to 0 on entry to DATA and wraps to 0 on exit.
- No illegal state may lock up: any unused state encoding goes to IDLE on the next edge.

Test Plan:
1. Reset check: hold rst_txf low for 3 cycles, then release, with no valid -> tx_out_txf=1 and busy_txf=0 throughout. Pulsing rst_txf low mid-DATA (between edges) -> tx=1 and busy=0 immediately, then IDLE.
2. 0xA5, par_en=1, par_typ=0 -> line carries 0,1,0,1,0,0,1,0,1,0(parity),1(stop). busy is high for exactly 11 cycles starting the edge after valid.
3. 0x00, par_en=1, par_typ=1 -> 0, eight 0s, 1 (odd parity), 1 (stop).
4. 0xFF, par_en=0 -> 0, eight 1s, 1 (stop). busy is high for exactly 10 cycles, with no parity slot.
5. Strobe 0x3C, then strobe 0xC3 during data bit 4 and again during the STOP cycle -> only 0x3C is transmitted; the line is idle afterwards. A fresh strobe of 0xC3 in IDLE is sent correctly, and its start bit comes no earlier than one IDLE cycle after STOP.
6. Back-to-back: strobe 0x55, then strobe 0xAA on the first cycle busy_txf=0 -> two complete frames separated by exactly one idle-high cycle. Changing p_data_txf and par_typ_txf during frame 1 has no effect on frame 1.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// Host-side handshake and serial-line signals of the UART transmit framer.
// The master modport drives the byte and strobe; the slave (the framer) drives the line.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data_txf;
  logic                  data_valid_txf;
  logic                  par_en_txf;
  logic                  par_typ_txf;
  logic                  tx_out_txf;
  logic                  busy_txf;

  modport master (
    output p_data_txf,
    output data_valid_txf,
    output par_en_txf,
    output par_typ_txf,
    input  tx_out_txf,
    input  busy_txf
  );

  modport slave (
    input  p_data_txf,
    input  data_valid_txf,
    input  par_en_txf,
    input  par_typ_txf,
    output tx_out_txf,
    output busy_txf
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional even/odd parity, one stop bit.
// One bit per clk_txf cycle; tx_out_txf and busy_txf are registered.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk_txf,
  input  logic           rst_txf,
  uart_tx_frame_if.slave txf
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk_txf or negedge rst_txf) begin
    if (!rst_txf) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      cnt_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs are derived from the next state so the line changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    cnt_d     = cnt_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (txf.data_valid_txf) begin
          data_d    = txf.p_data_txf;
          par_en_d  = txf.par_en_txf;
          par_typ_d = txf.par_typ_txf;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = data_d[cnt_d];
        busy_d = 1'b1;
      end
      PARITY: begin
        tx_d   = (^data_d) ^ par_typ_d;
        busy_d = 1'b1;
      end
      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign txf.tx_out_txf = tx_q;
  assign txf.busy_txf   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: each frame is compared bit-by-bit against hand-built line sequences.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  logic clk_txf;
  logic rst_txf;
  int   checkCount;
  int   errCount;

  uart_tx_frame_if #(.DATA_WIDTH(8)) txf_bus ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk_txf (clk_txf),
    .rst_txf (rst_txf),
    .txf     (txf_bus)
  );

  initial clk_txf = 1'b0;
  always #5 clk_txf = ~clk_txf;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_tx"}, 32'(txf_bus.tx_out_txf), 32'd1);
    checkOutput({tag, "_busy"}, 32'(txf_bus.busy_txf), 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parTyp);
    txf_bus.p_data_txf     = data;
    txf_bus.par_en_txf     = parEn;
    txf_bus.par_typ_txf    = parTyp;
    txf_bus.data_valid_txf = 1'b1;
  endtask

  // expSeq holds the line in send order, first bit at expSeq[len-1]; injMask[i] strobes injData during bit i.
  task automatic runFrame(input string tag, input logic [7:0] data, input logic parEn, input logic parTyp,
                          input logic [15:0] expSeq, input int len, input logic [15:0] injMask,
                          input logic [7:0] injData, input bit scramble);
    applyStimulus(data, parEn, parTyp);
    @(negedge clk_txf);
    txf_bus.data_valid_txf = 1'b0;
    for (int i = 0; i < len; i++) begin
      checkOutput($sformatf("%s_tx%0d", tag, i), 32'(txf_bus.tx_out_txf), 32'(expSeq[len-1-i]));
      checkOutput($sformatf("%s_busy%0d", tag, i), 32'(txf_bus.busy_txf), 32'd1);
      txf_bus.data_valid_txf = injMask[i];
      if (injMask[i]) txf_bus.p_data_txf = injData;
      if (scramble) begin
        txf_bus.p_data_txf  = 8'($urandom);
        txf_bus.par_typ_txf = ~txf_bus.par_typ_txf;
        txf_bus.par_en_txf  = ~txf_bus.par_en_txf;
      end
      @(negedge clk_txf);
    end
    txf_bus.data_valid_txf = 1'b0;
    checkIdle({tag, "_post"});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errCount   = 0;
    rst_txf    = 1'b0;
    txf_bus.p_data_txf     = 8'h00;
    txf_bus.data_valid_txf = 1'b0;
    txf_bus.par_en_txf     = 1'b0;
    txf_bus.par_typ_txf    = 1'b0;

    $display("[TB] reset hold");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_txf);
      checkIdle($sformatf("rst%0d", i));
    end
    rst_txf = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_txf);
      checkIdle($sformatf("rel%0d", i));
    end

    $display("[TB] 0xA5 even parity");
    runFrame("a5", 8'hA5, 1'b1, 1'b0, 16'b01010010101, 11, 16'h0, 8'h00, 1'b0);

    $display("[TB] 0x00 odd parity");
    runFrame("z0", 8'h00, 1'b1, 1'b1, 16'b00000000011, 11, 16'h0, 8'h00, 1'b0);

    $display("[TB] 0xFF no parity");
    runFrame("ff", 8'hFF, 1'b0, 1'b0, 16'b0111111111, 10, 16'h0, 8'h00, 1'b0);

    $display("[TB] strobes while busy are dropped");
    runFrame("3c", 8'h3C, 1'b0, 1'b0, 16'b0001111001, 10, 16'b0000_0010_0010_0000, 8'hC3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkIdle($sformatf("gap%0d", i));
      @(negedge clk_txf);
    end
    runFrame("c3", 8'hC3, 1'b1, 1'b0, 16'b01100001101, 11, 16'h0, 8'h00, 1'b0);

    $display("[TB] back-to-back with mid-frame input changes");
    runFrame("55", 8'h55, 1'b1, 1'b0, 16'b01010101001, 11, 16'h0, 8'h00, 1'b1);
    runFrame("aa", 8'hAA, 1'b1, 1'b1, 16'b00101010111, 11, 16'h0, 8'h00, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h00, 1'b1, 1'b0);
    @(negedge clk_txf);
    txf_bus.data_valid_txf = 1'b0;
    repeat (3) @(negedge clk_txf);
    checkOutput("mid_pre_tx", 32'(txf_bus.tx_out_txf), 32'd0);
    checkOutput("mid_pre_busy", 32'(txf_bus.busy_txf), 32'd1);
    #2 rst_txf = 1'b0;
    #1 checkIdle("mid_async");
    @(negedge clk_txf);
    rst_txf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_txf);
      checkIdle($sformatf("mid_idle%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
